// File: rtl/board_reset_io.sv
// board_reset_io: SoC reset sequencing from PLL lock, button debounce with edge pulses,
// and per-channel PWM LED drive gated by the SoC reset.
module board_reset_io #(
    parameter int RESET_CYCLES    = 255,
    parameter int NBUT            = 2,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int NLED            = 2,
    parameter int PWM_W           = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pll_locked,
    input  logic                    soft_rst_req,
    output logic                    sys_reset_n,
    input  logic [NBUT-1:0]         but_i,
    output logic [NBUT-1:0]         but_o,
    output logic [NBUT-1:0]         but_rise,
    output logic [NBUT-1:0]         but_fall,
    input  logic [NLED-1:0]         led_i,
    input  logic [NLED*PWM_W-1:0]   led_duty,
    output logic [NLED-1:0]         led_o
);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       lock_q;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic             sys_q, sys_d;
    logic [NBUT-1:0]  bs1_q, bs2_q, but_q, but_d, rise_q, rise_d, fall_q, fall_d;
    logic [DW-1:0]    dcnt_q [NBUT];
    logic [DW-1:0]    dcnt_d [NBUT];
    logic [PWM_W-1:0] pc_q;
    logic [NLED-1:0]  led_q, led_d;

    always_comb begin
        rcnt_d = rcnt_q;
        sys_d  = 1'b0;
        if (!lock_q[1] || soft_rst_req) rcnt_d = '0;
        else if (rcnt_q != RW'(RESET_CYCLES)) rcnt_d = rcnt_q + 1'b1;
        else sys_d = 1'b1;
        but_d  = but_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < NBUT; i++) begin
            dcnt_d[i] = '0;
            if (bs2_q[i] != but_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    but_d[i]  = bs2_q[i];
                    rise_d[i] = bs2_q[i];
                    fall_d[i] = !bs2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
        // full-scale duty bypasses the compare so the LED never has a dark cycle
        for (int i = 0; i < NLED; i++)
            led_d[i] = sys_q & led_i[i] &
                       ((&led_duty[i*PWM_W +: PWM_W]) | (pc_q < led_duty[i*PWM_W +: PWM_W]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= '0;
            rcnt_q <= '0;
            sys_q  <= 1'b0;
            bs1_q  <= '0;
            bs2_q  <= '0;
            but_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < NBUT; i++) dcnt_q[i] <= '0;
            pc_q   <= '0;
            led_q  <= '0;
        end else begin
            lock_q <= {lock_q[0], pll_locked};
            rcnt_q <= rcnt_d;
            sys_q  <= sys_d;
            bs1_q  <= but_i;
            bs2_q  <= bs1_q;
            but_q  <= but_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < NBUT; i++) dcnt_q[i] <= dcnt_d[i];
            pc_q   <= pc_q + 1'b1;
            led_q  <= led_d;
        end
    end

    assign sys_reset_n = sys_q;
    assign but_o       = but_q;
    assign but_rise    = rise_q;
    assign but_fall    = fall_q;
    assign led_o       = led_q;
endmodule

// File: tb/tb_board_reset_io.sv
// tb_board_reset_io: randomized and directed stimulus with a per-cycle scoreboard fed by
// a run-length behavioural model of reset, debounce and PWM behaviour.
module tb_board_reset_io;
    localparam int RC = 8;
    localparam int DC = 4;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pll_locked = 1'b0;
    logic soft_rst_req = 1'b0;
    logic sys_reset_n;
    logic [1:0] but_i = '0;
    logic [1:0] but_o, but_rise, but_fall;
    logic [1:0] led_i = '0;
    logic [2*PW-1:0] led_duty = '0;
    logic [1:0] led_o;

    int checks = 0;
    int errors = 0;

    board_reset_io #(
        .RESET_CYCLES(RC), .NBUT(2), .DEBOUNCE_CYCLES(DC), .NLED(2), .PWM_W(PW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
        .sys_reset_n(sys_reset_n), .but_i(but_i), .but_o(but_o), .but_rise(but_rise),
        .but_fall(but_fall), .led_i(led_i), .led_duty(led_duty), .led_o(led_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sys;
        logic [1:0] but;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] led;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    // Model: sys is high once lock_s has been good (and no soft request) for RC+1 edges in a
    // row; a button flips after DC consecutive edges of disagreement; pc counts edges mod 2^PW.
    int   good_run, brun[2];
    logic m_sys;
    logic [1:0] pll_hist, bs1, bs2, bdeb;
    int   pc;

    always @(posedge clk) begin
        exp_t e;
        e = '0;
        if (!reset_n) begin
            good_run = 0; m_sys = 0; pll_hist = 0; bs1 = 0; bs2 = 0; bdeb = 0;
            brun[0] = 0; brun[1] = 0; pc = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                int d;
                d = led_duty[i*PW +: PW];
                e.led[i] = m_sys && led_i[i] && (d == (1 << PW) - 1 || pc < d);
            end
            pc = (pc + 1) % (1 << PW);
            if (pll_hist[1] && !soft_rst_req) good_run = good_run < 1000 ? good_run + 1 : good_run;
            else good_run = 0;
            m_sys = good_run >= RC + 1;
            pll_hist = {pll_hist[0], pll_locked};
            for (int i = 0; i < 2; i++) begin
                brun[i] = (bs2[i] != bdeb[i]) ? brun[i] + 1 : 0;
                if (brun[i] == DC) begin
                    bdeb[i] = bs2[i];
                    e.rise[i] = bs2[i];
                    e.fall[i] = !bs2[i];
                    brun[i] = 0;
                end
            end
            bs2 = bs1;
            bs1 = but_i;
            e.sys = m_sys;
            e.but = bdeb;
        end
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            sb.delete();
            chk("sys_reset_n in reset", {31'b0, sys_reset_n}, 0);
            chk("outputs in reset", {24'b0, but_o, but_rise, but_fall, led_o}, 0);
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sys_reset_n", {31'b0, sys_reset_n}, {31'b0, e.sys});
            chk("but_o", {30'b0, but_o}, {30'b0, e.but});
            chk("but_rise", {30'b0, but_rise}, {30'b0, e.rise});
            chk("but_fall", {30'b0, but_fall}, {30'b0, e.fall});
            chk("led_o", {30'b0, led_o}, {30'b0, e.led});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic count_led(input int ch, input int want, input string name);
        int hits;
        hits = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            hits += led_o[ch];
        end
        chk(name, hits, want);
    endtask

    initial begin
        step(3);
        reset_n = 1'b1;
        led_i = 2'b11;
        led_duty = {4'd15, 4'd5};
        step(2);
        pll_locked = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("sys low after edge 10", {31'b0, sys_reset_n}, 0);
        @(posedge clk);
        #1 chk("sys high after edge 11", {31'b0, sys_reset_n}, 1);
        #1;
        step(2);
        count_led(0, 5, "led0 duty 5 on-cycles");
        count_led(1, 16, "led1 duty 15 on-cycles");
        #2 led_duty[3:0] = 4'd0;
        step(2);
        count_led(0, 0, "led0 duty 0 on-cycles");
        #2 led_duty[3:0] = 4'd9;
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(15);
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        step(4);
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        step(14);
        but_i[0] = 1'b1;
        step(10);
        but_i[1] = 1'b1;
        step(3);
        but_i[1] = 1'b0;
        step(10);
        but_i[0] = 1'b0;
        step(10);
        for (int k = 0; k < 500; k++) begin
            soft_rst_req = ($urandom_range(0, 59) == 0);
            pll_locked = ($urandom_range(0, 79) != 0);
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 5) == 0) but_i[i] = ~but_i[i];
            if (k % 25 == 0) begin
                led_i = 2'($urandom_range(0, 3));
                led_duty = 8'($urandom);
            end
            step(1);
        end
        soft_rst_req = 1'b0;
        pll_locked = 1'b1;
        but_i = 2'b00;
        step(20);
        but_i = 2'b11;
        step(3);
        reset_n = 1'b0;
        #1;
        chk("async clear sys", {31'b0, sys_reset_n}, 0);
        chk("async clear buttons", {26'b0, but_o, but_rise, but_fall}, 0);
        chk("async clear led", {30'b0, led_o}, 0);
        step(2);
        reset_n = 1'b1;
        step(30);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/board_reset_io.md
# board_reset_io

Parametrised board-level reset and I/O conditioning block. It sits between the FPGA pins/PLL and `soc_6502`. It generates the SoC reset from PLL lock with a programmable hold time and restarts that reset on lock loss or a software request. It also synchronises and debounces N push-buttons, emitting level plus edge pulses, and drives M LEDs with per-channel PWM brightness.

## Interface
Parameters:
- `RESET_CYCLES`, 255: clock cycles `sys_reset_n` is held low after a valid lock; ≥1.
- `NBUT`, 2: number of button channels.
- `DEBOUNCE_CYCLES`, 65535: consecutive stable cycles required to accept a button change; ≥1.
- `NLED`, 2: number of LED channels.
- `PWM_W`, 8: PWM counter / duty width.

Ports:
- `clk` in 1: single system clock (PLL output).
- `reset_n` in 1: asynchronous, active-low reset of this block.
- `pll_locked` in 1: PLL lock, asynchronous to `clk`.
- `soft_rst_req` in 1: synchronous one-cycle request to restart the SoC reset sequence.
- `sys_reset_n` out 1: registered active-low reset to the SoC.
- `but_i` in NBUT: raw button pins, asynchronous.
- `but_o` out NBUT: debounced button level.
- `but_rise` out NBUT: one-cycle pulse per channel on a debounced 0→1 transition.
- `but_fall` out NBUT: one-cycle pulse per channel on a debounced 1→0 transition.
- `led_i` in NLED: LED enable from GPIO.
- `led_duty` in NLED*PWM_W: per-channel duty; channel i uses bits [i*PWM_W +: PWM_W].
- `led_o` out NLED: registered LED drive.

## Operation
- On `reset_n` low, all of the following clear to 0 asynchronously: `sys_reset_n`, `but_o`, `but_rise`, `but_fall`, `led_o`, all synchroniser flops, the reset counter, the debounce counters and the PWM counter.
- Reset generator:
  - `pll_locked` passes through a 2-flop synchroniser; its output is `lock_s`.
  - If `lock_s`=0 or `soft_rst_req`=1: counter ← 0 and `sys_reset_n` ← 0. This rule has priority.
  - Otherwise, if counter ≠ `RESET_CYCLES`: counter increments and `sys_reset_n` ← 0.
  - Otherwise: `sys_reset_n` ← 1, and the counter holds.
  - The counter width is clog2(`RESET_CYCLES`+1). The counter never wraps.
- Button channels are independent. Each channel has a 2-flop synchroniser with output `s`, plus a debounce counter of width clog2(`DEBOUNCE_CYCLES`).
  - If `s` == `but_o`: counter ← 0.
  - Else, if counter == `DEBOUNCE_CYCLES`-1: `but_o` ← `s`, counter ← 0, and `but_rise`/`but_fall` ← 1 according to direction.
  - Else: counter increments.
  - `but_rise`/`but_fall` are 0 in every other cycle.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles resets the counter and produces no change.
  - Buttons operate independently of `sys_reset_n`, so the SoC sees button state while it is held in reset.
- PWM:
  - A free-running `PWM_W`-bit counter `pc` wraps from 2^PWM_W-1 to 0.
  - `led_o[i]` ← `sys_reset_n` & `led_i[i]` & (duty_i == 2^PWM_W-1 | `pc` < duty_i).
  - Duty 0 means always off. Duty at maximum means always on; there is no dark cycle.
  - Duty k (for 0 < k < 2^PWM_W-1) gives exactly k on-cycles per 2^PWM_W-cycle period.
  - LEDs are forced off while the SoC is in reset.

## Timing
- `pll_locked` rises (edge 1 is the first edge sampling 1): `sys_reset_n` reads 1 after edge `RESET_CYCLES`+3.
- `pll_locked` falls: `sys_reset_n` reads 0 after the 3rd edge.
- `soft_rst_req` high at an edge: `sys_reset_n` reads 0 after that same edge. The full `RESET_CYCLES`+1 sequence then restarts.
- A simultaneous lock loss and `soft_rst_req` behave identically to either event alone.
- Button pin change, stable thereafter: `but_o` and the pulse change after edge `DEBOUNCE_CYCLES`+2. The pulse width is exactly 1 cycle.
- A button stuck at 1 through `reset_n` release produces one `but_rise` after `DEBOUNCE_CYCLES`+2 edges.
- LED output has a 1-cycle latency from `led_i`/`led_duty`/`pc`.
- Asserting `reset_n` mid-sequence or mid-debounce clears state immediately. Deasserting it restarts all behaviour from the reset values.

## Test plan
All scenarios use `RESET_CYCLES`=8, `DEBOUNCE_CYCLES`=4, `PWM_W`=4.
- Lock sequence: `pll_locked` 0→1 → `sys_reset_n` 0 through edge 10, 1 after edge 11; `led_o`=0 throughout the low phase.
- Lock loss: drop `pll_locked` for 1 cycle while `sys_reset_n`=1 → `sys_reset_n` 0 after the 3rd edge, back to 1 after 11 edges from re-lock.
- Soft reset: pulse `soft_rst_req` once with lock stable → `sys_reset_n` 0 on the next edge, 1 again 9 edges later. A second pulse mid-count restarts the count from 0.
- Debounce: hold `but_i[0]` 0→1 → `but_o[0]`=1 and a single `but_rise[0]` pulse after edge 6. A 3-cycle high glitch on `but_i[1]` → no change and no pulse on channel 1.
- PWM: `led_i`=2'b11 with duty0=5, duty1=15 → over 16 cycles, `led_o[0]` is high for exactly 5 cycles and `led_o[1]` for all 16. Duty 0 → never high.
- Async reset: assert `reset_n` mid-debounce and mid-reset-count → all outputs read 0 immediately without a clock edge. After release, the sequences restart from the start.
